// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: machine word and RAM handshake state.
package cpu_types_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

// File: rtl/dp_types_pkg.sv
// Datapath-side types for the memory arbiter FSM and its round-robin grant.
package dp_types_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;
endpackage

// File: rtl/mem_arbiter.sv
// Serialises instruction fetches and data accesses onto one RAM port.
// Optional abort-on-timeout logic is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import cpu_types_pkg::*;
    import dp_types_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      ihit,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dhit,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      timeout
);

    arb_state_t r_state;
    arb_state_t w_next;
    grant_t     r_last;
    logic       r_ren;
    logic       r_wen;
    word_t      r_addr;
    word_t      r_store;

    logic w_acc;
    logic w_access;
    logic w_abort;
    logic w_dpend;
    logic w_dmatch;
    logic w_imatch;

    assign w_acc    = (r_state != IDLE);
    assign w_access = w_acc && (ramstate == ACCESS);
    assign w_dpend  = dREN | dWEN;

    // Hit only if the requester still wants exactly what was latched.
    assign w_dmatch = (r_wen ? dWEN : dREN) && (daddr == r_addr);
    assign w_imatch = iREN && (iaddr == r_addr);

    assign ihit = w_access && (r_state == IACC) && w_imatch;
    assign dhit = w_access && (r_state == DACC) && w_dmatch;

    assign iload    = ramload;
    assign dload    = ramload;
    assign ramREN   = w_acc && r_ren;
    assign ramWEN   = w_acc && r_wen;
    assign ramaddr  = r_addr;
    assign ramstore = r_store;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_dpend && iREN)
                    w_next = (r_last == GRANT_D) ? IACC : DACC;
                else if (w_dpend)
                    w_next = DACC;
                else if (iREN)
                    w_next = IACC;
            end
            DACC, IACC: begin
                if (w_access || w_abort)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_last  <= GRANT_D;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_store <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_next == DACC) begin
                r_ren   <= dREN;
                r_wen   <= dWEN & ~dREN;
                r_addr  <= daddr;
                r_store <= dstore;
            end else if (r_state == IDLE && w_next == IACC) begin
                r_ren  <= 1'b1;
                r_wen  <= 1'b0;
                r_addr <= iaddr;
            end
            if (w_access || w_abort)
                r_last <= (r_state == DACC) ? GRANT_D : GRANT_I;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_timeout;

    // Abort on the last waiting cycle so exactly TIMEOUT_CYCLES are spent.
    assign w_abort = w_acc && (ramstate != ACCESS) && (r_cnt == LIMIT);
    assign timeout = r_timeout;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!w_acc)
                r_cnt <= '0;
            else if (ramstate != ACCESS && !w_abort)
                r_cnt <= r_cnt + 1'b1;
            if (w_abort)
                r_timeout <= 1'b1;
        end
    end
`else
    assign w_abort = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Inputs change after the falling edge; outputs are checked before the next rising edge.
module tb_mem_arbiter;
    import cpu_types_pkg::*;
    import dp_types_pkg::*;

    logic      CLK;
    logic      nRST;
    logic      iREN;
    word_t     iaddr;
    logic      ihit;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dhit;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      timeout;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .timeout(timeout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        iREN = 0; iaddr = '0;
        dREN = 0; dWEN = 0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = FREE;
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ren"}, {31'd0, ramREN}, 32'd0);
        chk({tag, "_wen"}, {31'd0, ramWEN}, 32'd0);
    endtask

    initial begin
        do_reset();
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_dhit", {31'd0, dhit}, 32'd0);
        chk_idle("rst");
        chk("rst_to", {31'd0, timeout}, 32'd0);
        chk("rst_addr", ramaddr, 32'd0);
        chk("rst_store", ramstore, 32'd0);

        // 1: data read, two BUSY cycles then ACCESS
        dREN = 1; daddr = 32'h100; ramstate = BUSY;
        #1 chk_idle("t1_req");
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("t1_ren", {31'd0, ramREN}, 32'd1);
            chk("t1_addr", ramaddr, 32'h100);
            chk("t1_dhit_busy", {31'd0, dhit}, 32'd0);
        end
        tick();
        ramstate = ACCESS; ramload = 32'hDEADBEEF;
        #1;
        chk("t1_ren3", {31'd0, ramREN}, 32'd1);
        chk("t1_dhit", {31'd0, dhit}, 32'd1);
        chk("t1_dload", dload, 32'hDEADBEEF);
        chk("t1_ihit", {31'd0, ihit}, 32'd0);
        dREN = 0;
        tick();
        ramstate = FREE;
        #1;
        chk_idle("t1_done");
        chk("t1_dhit_after", {31'd0, dhit}, 32'd0);

        // 2: contention from reset, round robin I, D, I, D
        do_reset();
        iREN = 1; iaddr = 32'h0;
        dWEN = 1; daddr = 32'h200; dstore = 32'h12345678;
        ramstate = BUSY;
        tick();
        chk("t2_i_ren", {31'd0, ramREN}, 32'd1);
        chk("t2_i_wen", {31'd0, ramWEN}, 32'd0);
        chk("t2_i_addr", ramaddr, 32'h0);
        tick();
        ramstate = ACCESS; #1;
        chk("t2_ihit", {31'd0, ihit}, 32'd1);
        chk("t2_dhit0", {31'd0, dhit}, 32'd0);
        tick();
        ramstate = BUSY; #1;
        chk_idle("t2_gap");
        tick();
        chk("t2_d_wen", {31'd0, ramWEN}, 32'd1);
        chk("t2_d_ren", {31'd0, ramREN}, 32'd0);
        chk("t2_d_addr", ramaddr, 32'h200);
        chk("t2_d_store", ramstore, 32'h12345678);
        tick();
        ramstate = ACCESS; #1;
        chk("t2_dhit", {31'd0, dhit}, 32'd1);
        chk("t2_ihit0", {31'd0, ihit}, 32'd0);
        dWEN = 0; dREN = 1; daddr = 32'h204;
        tick();
        ramstate = BUSY; #1;
        chk_idle("t2_gap2");
        tick();
        chk("t2_i2_addr", ramaddr, 32'h0);
        chk("t2_i2_ren", {31'd0, ramREN}, 32'd1);
        ramstate = ACCESS; #1;
        chk("t2_ihit2", {31'd0, ihit}, 32'd1);
        iREN = 0;
        tick();
        ramstate = BUSY;
        tick();
        chk("t2_d2_addr", ramaddr, 32'h204);
        chk("t2_d2_ren", {31'd0, ramREN}, 32'd1);
        ramstate = ACCESS; #1;
        chk("t2_dhit2", {31'd0, dhit}, 32'd1);
        dREN = 0;
        tick();

        // 3: ERROR retries on an instruction read
        do_reset();
        iREN = 1; iaddr = 32'h40; ramstate = ERROR;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("t3_ren", {31'd0, ramREN}, 32'd1);
            chk("t3_addr", ramaddr, 32'h40);
            chk("t3_ihit_err", {31'd0, ihit}, 32'd0);
        end
        tick();
        ramstate = ACCESS; #1;
        chk("t3_ren_acc", {31'd0, ramREN}, 32'd1);
        chk("t3_ihit", {31'd0, ihit}, 32'd1);
        iREN = 0;
        tick();
        ramstate = FREE; #1;
        chk_idle("t3_done");
        chk("t3_ihit_after", {31'd0, ihit}, 32'd0);

        // 4: flushed read completes on RAM without a hit
        do_reset();
        dREN = 1; daddr = 32'h300; ramstate = BUSY;
        tick();
        chk("t4_ren", {31'd0, ramREN}, 32'd1);
        dREN = 0; ramstate = ACCESS; #1;
        chk("t4_ren_acc", {31'd0, ramREN}, 32'd1);
        chk("t4_addr", ramaddr, 32'h300);
        chk("t4_dhit", {31'd0, dhit}, 32'd0);
        tick();
        chk_idle("t4_idle");

        // 5: asynchronous reset in the middle of a store
        do_reset();
        dWEN = 1; daddr = 32'h500; dstore = 32'hA5A5A5A5; ramstate = BUSY;
        tick();
        chk("t5_wen", {31'd0, ramWEN}, 32'd1);
        ramstate = ACCESS;
        #1 nRST = 1'b0;
        #1;
        chk("t5_wen_rst", {31'd0, ramWEN}, 32'd0);
        chk("t5_dhit_rst", {31'd0, dhit}, 32'd0);
        chk("t5_addr_rst", ramaddr, 32'h0);
        dWEN = 0;
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        chk_idle("t5_idle");
        chk("t5_dhit_idle", {31'd0, dhit}, 32'd0);

        // 6: RAM stuck BUSY
        do_reset();
        iREN = 1; iaddr = 32'h80; ramstate = BUSY;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t6_wait_ren", {31'd0, ramREN}, 32'd1);
            chk("t6_wait_to", {31'd0, timeout}, 32'd0);
        end
        tick();
`ifdef MEM_ARB_TIMEOUT_EN
        chk("t6_abort_ren", {31'd0, ramREN}, 32'd0);
        chk("t6_abort_to", {31'd0, timeout}, 32'd1);
        chk("t6_abort_ihit", {31'd0, ihit}, 32'd0);
        tick();
        chk("t6_regrant", {31'd0, ramREN}, 32'd1);
        chk("t6_regrant_addr", ramaddr, 32'h80);
        chk("t6_sticky", {31'd0, timeout}, 32'd1);
`else
        chk("t6_still_ren", {31'd0, ramREN}, 32'd1);
        chk("t6_to_off", {31'd0, timeout}, 32'd0);
        tick();
        chk("t6_still_ren2", {31'd0, ramREN}, 32'd1);
`endif
        ramstate = ACCESS; #1;
        chk("t6_ihit", {31'd0, ihit}, 32'd1);
        iREN = 0;
        tick();
        ramstate = FREE; #1;
        chk_idle("t6_done");
`ifdef MEM_ARB_TIMEOUT_EN
        chk("t6_sticky_end", {31'd0, timeout}, 32'd1);
`else
        chk("t6_to_end", {31'd0, timeout}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
